gray_counter_sequencer: RTL and testbench

Command-driven controller for the 4-bit gray code counter.
- Accepts LOAD / HOLD / UP / DOWN commands over a valid/ready interface and queues them in a small FIFO.
- Sequences the counter's en/ctrl1/ctrl2/register_in lines for the commanded number of clock cycles.
- Keeps a binary shadow of the counter's internal count so software and the bench can predict the gray output.
- Sits between the control block and the counter; it is the only driver of the counter's control pins.

---
 rtl/gray_ctr_pkg.sv | 34 +++
 rtl/gray_counter_sequencer_cmd_fifo.sv | 41 ++++
 rtl/gray_counter_sequencer.sv | 152 +++++++++++++++
 tb/tb_gray_counter_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_ctr_pkg.sv
// Shared encodings for the gray counter sequencer: command ops, counter
// control pairs and sequencer FSM states.
package gray_ctr_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_HOLD = 2'b01,
        OP_UP   = 2'b10,
        OP_DOWN = 2'b11
    } op_e;

    // {ctrl1, ctrl2} as the counter decodes them
    localparam logic [1:0] CTRL_LOAD = 2'b00;
    localparam logic [1:0] CTRL_HOLD = 2'b01;
    localparam logic [1:0] CTRL_UP   = 2'b10;
    localparam logic [1:0] CTRL_DOWN = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_e;

    function automatic logic [1:0] op_to_ctrl(input op_e op);
        logic [1:0] ctrl;
        case (op)
            OP_LOAD: ctrl = CTRL_LOAD;
            OP_UP:   ctrl = CTRL_UP;
            OP_DOWN: ctrl = CTRL_DOWN;
            default: ctrl = CTRL_HOLD;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/gray_counter_sequencer_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit so full and
// empty are decoded from registered state only.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/gray_counter_sequencer.sv
// Command-driven sequencer for the 4-bit gray counter: queues LOAD/HOLD/UP/DOWN
// commands and drives the counter's control pins, tracking a binary shadow.
module gray_counter_sequencer
    import gray_ctr_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    output logic [WIDTH-1:0] ctr_in,
    output logic             ctr_ctrl1,
    output logic             ctr_ctrl2,
    output logic             ctr_en,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] shadow,
    output logic             shadow_valid,
    output logic [WIDTH-1:0] gray_expect
);

    localparam int CW = 2 + WIDTH;
    localparam int RW = WIDTH + 1;

    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic [CW-1:0] fifo_dout;
    op_e           head_op;
    logic [WIDTH-1:0] head_arg;
    logic [RW-1:0] head_steps;

    state_e        state, state_n;
    op_e           cur_op, cur_op_n;
    logic [RW-1:0] remaining, remaining_n;
    logic          take_next;
    logic          en_n;
    logic          done_n;
    logic [1:0]    ctrl_n;
    logic [WIDTH-1:0] ctr_in_n;
    logic [WIDTH-1:0] shadow_n;
    logic          shadow_valid_n;

    // Valid/ready: a command transfers on a rising edge where cmd_valid and
    // cmd_ready are both high; cmd_ready depends only on FIFO occupancy.
    assign cmd_ready = !fifo_full;

    cmd_fifo #(
        .DEPTH(DEPTH),
        .DW   (CW)
    ) u_cmd_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (cmd_valid && cmd_ready),
        .pop  (fifo_pop),
        .din  ({cmd_op, cmd_arg}),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    assign head_op    = op_e'(fifo_dout[CW-1 -: 2]);
    assign head_arg   = fifo_dout[WIDTH-1:0];
    // An argument of zero encodes a full lap of 2^WIDTH steps
    assign head_steps = (head_op == OP_LOAD) ? RW'(1) :
                        (head_arg == '0)     ? {1'b1, {WIDTH{1'b0}}} : RW'(head_arg);

    assign busy        = (state == ST_EXEC) || !fifo_empty;
    assign gray_expect = shadow ^ (shadow >> 1);

    always_comb begin
        state_n        = state;
        cur_op_n       = cur_op;
        remaining_n    = remaining;
        take_next      = 1'b0;
        en_n           = 1'b0;
        done_n         = 1'b0;
        ctrl_n         = CTRL_HOLD;
        ctr_in_n       = ctr_in;
        shadow_n       = shadow;
        shadow_valid_n = shadow_valid;
        fifo_pop       = 1'b0;

        // The counter acts on this edge; mirror it in the shadow
        if (ctr_en) begin
            case (cur_op)
                OP_LOAD: begin
                    shadow_n       = ctr_in;
                    shadow_valid_n = 1'b1;
                end
                OP_UP:   shadow_n = shadow + WIDTH'(1);
                OP_DOWN: shadow_n = shadow - WIDTH'(1);
                default: shadow_n = shadow;
            endcase
        end

        case (state)
            ST_IDLE: take_next = !fifo_empty;
            ST_EXEC: begin
                remaining_n = remaining - RW'(1);
                if (remaining == RW'(1)) begin
                    done_n    = 1'b1;
                    take_next = !fifo_empty;
                    if (fifo_empty) state_n = ST_IDLE;
                end else begin
                    en_n   = 1'b1;
                    ctrl_n = {ctr_ctrl1, ctr_ctrl2};
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (take_next) begin
            fifo_pop    = 1'b1;
            state_n     = ST_EXEC;
            cur_op_n    = head_op;
            remaining_n = head_steps;
            en_n        = 1'b1;
            ctrl_n      = op_to_ctrl(head_op);
            if (head_op == OP_LOAD) ctr_in_n = head_arg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                  <= ST_IDLE;
            cur_op                 <= OP_LOAD;
            remaining              <= '0;
            ctr_en                 <= 1'b0;
            {ctr_ctrl1, ctr_ctrl2} <= CTRL_HOLD;
            ctr_in                 <= '0;
            done                   <= 1'b0;
            shadow                 <= '0;
            shadow_valid           <= 1'b0;
        end else begin
            state                  <= state_n;
            cur_op                 <= cur_op_n;
            remaining              <= remaining_n;
            ctr_en                 <= en_n;
            {ctr_ctrl1, ctr_ctrl2} <= ctrl_n;
            ctr_in                 <= ctr_in_n;
            done                   <= done_n;
            shadow                 <= shadow_n;
            shadow_valid           <= shadow_valid_n;
        end
    end

endmodule

// File: tb/tb_gray_counter_sequencer.sv
// Bench for gray_counter_sequencer: a per-edge schedule of expected counter
// actions built from accepted commands, plus a behavioural gray counter.
module tb_gray_counter_sequencer;

    localparam int DEPTH = 4;
    localparam int WIDTH = 4;
    localparam int MAXC  = 8192;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cmd_arg = 4'd0;
    logic [3:0] ctr_in;
    logic       ctr_ctrl1, ctr_ctrl2, ctr_en, busy, done, shadow_valid;
    logic [3:0] shadow, gray_expect;

    gray_counter_sequencer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .ctr_in(ctr_in), .ctr_ctrl1(ctr_ctrl1),
        .ctr_ctrl2(ctr_ctrl2), .ctr_en(ctr_en), .busy(busy), .done(done),
        .shadow(shadow), .shadow_valid(shadow_valid), .gray_expect(gray_expect)
    );

    // ---------------- clock / reset ----------------
    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural gray counter driven by the DUT's control pins
    logic [3:0] cnt_bin = 4'd0;
    logic [3:0] cnt_gray;
    always @(posedge clk) begin
        if (ctr_en) begin
            case ({ctr_ctrl1, ctr_ctrl2})
                2'b00:   cnt_bin <= ctr_in;
                2'b10:   cnt_bin <= cnt_bin + 4'd1;
                2'b11:   cnt_bin <= cnt_bin - 4'd1;
                default: cnt_bin <= cnt_bin;
            endcase
        end
    end
    assign cnt_gray = cnt_bin ^ (cnt_bin >> 1);

    // ---------------- reference model ----------------
    int checks = 0;
    int errors = 0;
    bit in_reset = 1'b1;
    bit         exp_en   [MAXC];
    logic [1:0] exp_op   [MAXC];
    logic [3:0] exp_arg  [MAXC];
    bit         exp_done [MAXC];
    bit         exp_busy [MAXC];
    int         exp_occ  [MAXC];
    int         sched_last = 0;
    logic [3:0] sched_s = 4'd0;
    bit         sched_v = 1'b0;
    logic [4:0] exp_q[$];
    logic [3:0] ms = 4'd0;
    bit         mv = 1'b0;
    int         en_cnt = 0;
    int         done_cnt = 0;
    int         last_wait = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Command accepted at edge acc: actions start two edges later, or right
    // after the previous command's last action, whichever is later.
    task automatic schedule(input logic [1:0] op, input logic [3:0] arg, input int acc);
        int len, start, last;
        len   = (op == 2'b00) ? 1 : ((arg == 4'd0) ? 16 : int'(arg));
        start = (sched_last + 1 > acc + 2) ? sched_last + 1 : acc + 2;
        last  = start + len - 1;
        if (last >= MAXC - 2) begin
            errors++;
            checks++;
            $display("FAIL schedule_overflow: got %0d expected below %0d", last, MAXC - 2);
            return;
        end
        for (int e = start; e <= last; e++) begin
            exp_en[e]  = 1'b1;
            exp_op[e]  = op;
            exp_arg[e] = arg;
        end
        exp_done[last] = 1'b1;
        for (int k = acc; k < last; k++) exp_busy[k] = 1'b1;
        for (int k = acc; k < start - 1; k++) exp_occ[k]++;
        sched_last = last;
        case (op)
            2'b00: begin sched_s = arg; sched_v = 1'b1; end
            2'b10: sched_s = sched_s + 4'(len);
            2'b11: sched_s = sched_s - 4'(len);
            default: ;
        endcase
        exp_q.push_back({sched_v, sched_s});
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!in_reset && cyc < MAXC - 20) begin
            if (exp_en[cyc]) begin
                case (exp_op[cyc])
                    2'b00: begin ms = exp_arg[cyc]; mv = 1'b1; end
                    2'b10: ms = ms + 4'd1;
                    2'b11: ms = ms - 4'd1;
                    default: ;
                endcase
            end
            chk("ctr_en", ctr_en, exp_en[cyc+1]);
            if (exp_en[cyc+1]) begin
                chk("ctrl", {ctr_ctrl1, ctr_ctrl2}, exp_op[cyc+1]);
                if (exp_op[cyc+1] == 2'b00) chk("ctr_in", ctr_in, exp_arg[cyc+1]);
            end else begin
                chk("ctrl_idle", {ctr_ctrl1, ctr_ctrl2}, 2'b01);
            end
            chk("done", done, exp_done[cyc]);
            chk("busy", busy, exp_busy[cyc]);
            chk("cmd_ready", cmd_ready, exp_occ[cyc] < DEPTH);
            chk("shadow_valid", shadow_valid, mv);
            if (mv) begin
                chk("shadow", shadow, ms);
                chk("gray_expect", gray_expect, ms ^ (ms >> 1));
                chk("counter_out", cnt_gray, ms ^ (ms >> 1));
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("done_unexpected", done, 1'b0);
                end else begin
                    logic [4:0] e;
                    e = exp_q.pop_front();
                    chk("done_valid", shadow_valid, e[4]);
                    if (e[4]) chk("done_shadow", shadow, e[3:0]);
                end
            end
            if (ctr_en) en_cnt++;
            if (done) done_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_cmd(input logic [1:0] op, input logic [3:0] arg);
        int n;
        n = 0;
        @(negedge clk);
        cmd_op = op;
        cmd_arg = arg;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        last_wait = n;
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got cmd_ready 0 for %0d cycles expected 1", n);
            cmd_valid = 1'b0;
            return;
        end
        schedule(op, arg, cyc + 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || ctr_en) && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (n >= 600) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy %0d expected 0", busy);
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic clear_counts();
        en_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic do_async_reset();
        in_reset = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("arst_ctr_en", ctr_en, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_ready", cmd_ready, 1'b1);
        chk("arst_shadow_valid", shadow_valid, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_ctrl", {ctr_ctrl1, ctr_ctrl2}, 2'b01);
        for (int i = cyc; i < MAXC; i++) begin
            exp_en[i] = 1'b0;
            exp_done[i] = 1'b0;
            exp_busy[i] = 1'b0;
            exp_occ[i] = 0;
        end
        exp_q.delete();
        ms = 4'd0;
        mv = 1'b0;
        sched_s = 4'd0;
        sched_v = 1'b0;
        sched_last = 0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 in_reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctr_en", ctr_en, 1'b0);
        chk("rst_ctrl", {ctr_ctrl1, ctr_ctrl2}, 2'b01);
        chk("rst_ctr_in", ctr_in, 4'd0);
        chk("rst_done", done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_shadow", shadow, 4'd0);
        chk("rst_shadow_valid", shadow_valid, 1'b0);
        chk("rst_ready", cmd_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 in_reset = 1'b0;

        // LOAD 5
        clear_counts();
        push_cmd(2'b00, 4'd5);
        wait_idle();
        chk("load5_en_cycles", en_cnt, 1);
        chk("load5_done", done_cnt, 1);
        chk("load5_shadow", shadow, 4'd5);
        chk("load5_valid", shadow_valid, 1'b1);
        chk("load5_gray", gray_expect, 4'b0111);
        chk("load5_counter", cnt_gray, 4'b0111);

        // LOAD 0 then UP 3 back to back
        clear_counts();
        push_cmd(2'b00, 4'd0);
        push_cmd(2'b10, 4'd3);
        wait_idle();
        chk("up3_en_cycles", en_cnt, 4);
        chk("up3_done", done_cnt, 2);
        chk("up3_shadow", shadow, 4'd3);
        chk("up3_counter", cnt_gray, 4'b0010);

        // LOAD 1 then DOWN 3 wraps through zero
        clear_counts();
        push_cmd(2'b00, 4'd1);
        push_cmd(2'b11, 4'd3);
        wait_idle();
        chk("down3_shadow", shadow, 4'd14);
        chk("down3_gray", gray_expect, 4'b1001);
        chk("down3_counter", cnt_gray, 4'b1001);

        // HOLD 4 after LOAD 9
        push_cmd(2'b00, 4'd9);
        wait_idle();
        clear_counts();
        push_cmd(2'b01, 4'd4);
        wait_idle();
        chk("hold4_en_cycles", en_cnt, 4);
        chk("hold4_done", done_cnt, 1);
        chk("hold4_shadow", shadow, 4'd9);
        chk("hold4_counter", cnt_gray, 4'b1101);

        // Fill the FIFO behind a running UP 0 (16 steps)
        push_cmd(2'b00, 4'd7);
        wait_idle();
        clear_counts();
        for (int i = 0; i < DEPTH + 2; i++) begin
            push_cmd(2'b10, 4'd0);
            if (i == DEPTH) chk("fifo_last_slot_free", last_wait, 0);
        end
        chk("fifo_backpressure", last_wait > 0, 1'b1);
        wait_idle();
        chk("lap_done", done_cnt, DEPTH + 2);
        chk("lap_en_cycles", en_cnt, 16 * (DEPTH + 2));
        chk("lap_shadow", shadow, 4'd7);

        // Randomised command stream
        push_cmd(2'b00, 4'($urandom_range(0, 15)));
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
        end
        wait_idle();

        // Reset in the middle of UP 8, with a HOLD queued behind it
        push_cmd(2'b00, 4'd3);
        wait_idle();
        push_cmd(2'b10, 4'd8);
        push_cmd(2'b01, 4'd2);
        n = 0;
        while (!(shadow_valid && shadow == 4'd6) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL mid_up_timeout: got shadow %0d expected 6", shadow);
        end
        #2;
        do_async_reset();
        chk("frozen_counter", cnt_gray, 4'b0101);
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_valid", shadow_valid, 1'b0);
        push_cmd(2'b00, 4'd2);
        wait_idle();
        chk("reload_valid", shadow_valid, 1'b1);
        chk("reload_shadow", shadow, 4'd2);
        chk("reload_counter", cnt_gray, 4'b0011);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
